// File: rtl/mag_comp_seq.sv
// mag_comp_seq: sequential magnitude comparator.
//
// Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and
// reports gt/lt/eq with a start/busy/done handshake. Unsigned and
// two's-complement compares are selected per operation with signed_mode.
//
// Optional feature macro: MAG_COMP_EARLY_EXIT_EN
//   defined   : the compare finishes at the first differing chunk
//               (latency 1..NCH); equal operands still take NCH cycles.
//   undefined : always NCH compare cycles (constant latency).
//
// Handshake: start is sampled only while idle (busy=0, done=0); the
// operands and mode are captured on that edge and later input changes are
// ignored. busy is high for every compare cycle. done is a one-cycle pulse,
// and gt/lt/eq are valid from that cycle until the next completed compare
// or reset. A start seen while busy or done is dropped without effect.
module mag_comp_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NCH = WIDTH / ((CHUNK < 1) ? 1 : CHUNK);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  // Flipping the sign bit of both operands maps two's-complement onto
  // offset binary, so the chunk walk below stays a plain unsigned compare.
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  // Parameter sanity: reject illegal geometry at elaboration time.
  if (WIDTH < 2) begin : g_width_chk
    $error("mag_comp_seq: WIDTH (%0d) must be >= 2", WIDTH);
  end
  if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_chunk_chk
    $error("mag_comp_seq: WIDTH (%0d) must be an exact multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             r_eq_q, r_eq_d;
  logic             r_gt_q, r_gt_d;
  logic             r_lt_q, r_lt_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  // Current chunk of each operand, selected by the chunk index.
  logic [31:0]      bit_base;
  logic [CHUNK-1:0] ch_a;
  logic [CHUNK-1:0] ch_b;

  // Running flags after folding in the current chunk.
  logic             n_eq;
  logic             n_gt;
  logic             n_lt;
  logic             last_chunk;
  logic             finish;

  // Chunk select: shift the operand down by index*CHUNK and keep the low bits.
  always_comb begin
    bit_base = 32'(idx_q) * 32'(CHUNK);
    ch_a     = CHUNK'(a_q >> bit_base);
    ch_b     = CHUNK'(b_q >> bit_base);
  end

  // Fold the current chunk into the running flags; once a difference has
  // been seen the flags are frozen, so the most significant difference wins.
  always_comb begin
    n_eq = r_eq_q;
    n_gt = r_gt_q;
    n_lt = r_lt_q;
    if (r_eq_q) begin
      if (ch_a > ch_b) begin
        n_gt = 1'b1;
        n_eq = 1'b0;
      end else if (ch_a < ch_b) begin
        n_lt = 1'b1;
        n_eq = 1'b0;
      end
    end
    last_chunk = (idx_q == '0);
`ifdef MAG_COMP_EARLY_EXIT_EN
    finish = last_chunk | ~n_eq;
`else
    finish = last_chunk;
`endif
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    r_eq_d  = r_eq_q;
    r_gt_d  = r_gt_q;
    r_lt_d  = r_lt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = signed_mode ? (a ^ MSB_MASK) : a;
          b_d     = signed_mode ? (b ^ MSB_MASK) : b;
          idx_d   = IW'(NCH - 1);
          r_eq_d  = 1'b1;
          r_gt_d  = 1'b0;
          r_lt_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_eq_d = n_eq;
        r_gt_d = n_gt;
        r_lt_d = n_lt;
        idx_d  = idx_q - IW'(1);
        if (finish) begin
          gt_d    = n_gt;
          lt_d    = n_lt;
          eq_d    = n_eq;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and result registers; reset aborts any compare in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      r_eq_q  <= 1'b0;
      r_gt_q  <= 1'b0;
      r_lt_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      r_eq_q  <= r_eq_d;
      r_gt_q  <= r_gt_d;
      r_lt_q  <= r_lt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

  // A finished result always names exactly one relation.
  ast_done_onehot: assert property (@(posedge clk) disable iff (rst)
    done |-> $onehot({gt, lt, eq}));

  // busy and done are mutually exclusive phases of one operation.
  ast_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
    !(busy && done));

endmodule

// File: doc/mag_comp_seq.md
Name: mag_comp_seq

Overview:
- Parametrised sequential magnitude comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and reports gt/lt/eq with a start/busy/done handshake.
- Supports unsigned and two's-complement signed compares, selected per operation.
- Successor to the fixed-width combinational comparators. Used where wide operands must be compared with small per-cycle logic.

Parameters:
- WIDTH, 8: operand width in bits. Must be >= 2.
- CHUNK, 1: bits compared per cycle. WIDTH must be an exact multiple of CHUNK. A violation raises an elaboration/simulation $error.
- NCH (localparam), WIDTH/CHUNK: number of chunk-compare cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request a compare; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start
- a  input  WIDTH  operand A; latched with start
- b  input  WIDTH  operand B; latched with start
- busy  output  1  compare in progress
- done  output  1  one-cycle pulse; gt/lt/eq are valid from this cycle
- gt  output  1  A > B
- lt  output  1  A < B
- eq  output  1  A == B

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - busy=0, done=0, gt=0, lt=0, eq=0.
  - Internal operand registers, index and running flags are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge E0: latch a, b and signed_mode.
  - If signed_mode=1, invert bit WIDTH-1 of both latched operands. This maps two's-complement to offset binary; the rest of the compare is unsigned.
  - Running flags: r_eq=1, r_gt=0, r_lt=0. Chunk index = NCH-1 (top chunk).
  - Go to RUN. busy=1 from E0.
  - start=0: stay in IDLE.
- RUN, at each edge Ek (k=1..NCH), compare the current chunk of A and B:
  - r_eq=1 and chunkA>chunkB: r_gt=1, r_eq=0.
  - r_eq=1 and chunkA<chunkB: r_lt=1, r_eq=0.
  - r_eq=0: flags hold; the first differing chunk decides the result.
  - Decrement the index.
  - After the last chunk (index 0, edge E_NCH): register gt/lt/eq from the final flags, busy=0, done=1, go to DONE.
- DONE:
  - Lasts one cycle. Next edge: done=0, go to IDLE.
  - gt/lt/eq hold their value until the next accepted start's DONE, or until reset.
- Latency: done is high in the cycle after edge E_NCH, i.e. NCH cycles after the start edge.
- Throughput: one compare per NCH+2 cycles.
- start while busy or in DONE is ignored. It has no effect on latched operands or the result.
- Exactly one of gt/lt/eq is 1 whenever done=1 and thereafter until the next reset.
- Input changes on a, b or signed_mode after the start edge have no effect.
- Reset asserted mid-RUN or in DONE:
  - Operation is aborted; no done pulse.
  - Outputs clear per the reset rule.
  - After reset deasserts, the first start begins a fresh compare.

Optional Feature:
- Macro: MAG_COMP_EARLY_EXIT_EN
- Defined:
  - In RUN, as soon as a chunk compare sets r_gt or r_lt, register the result at that same edge, drop busy, assert done and go to DONE.
  - Latency = index of the first differing chunk from the top, plus 1 (range 1..NCH).
  - Equal operands still take NCH cycles.
- Undefined: always NCH RUN cycles regardless of data; latency is constant.

Test Plan:
- Equal operands: WIDTH=8, CHUNK=1, a=8'h5A, b=8'h5A, signed_mode=0, start pulse -> busy=1 for 8 cycles; done pulses 8 cycles after start edge with eq=1, gt=0, lt=0; busy=0 in the done cycle.
- Signed vs unsigned: a=8'h80, b=8'h7F -> signed_mode=0 gives gt=1; signed_mode=1 gives lt=1. Also a=8'hFF, b=8'h01, signed_mode=1 -> lt=1.
- Early exit: a=8'hFF, b=8'h01, signed_mode=1 -> with MAG_COMP_EARLY_EXIT_EN, done 1 cycle after start; without it, done 8 cycles after start; lt=1 in both builds.
- Start while busy: start with a=8'h10, b=8'h20; at cycle 3 pulse start with a=8'h30, b=8'h01 -> second start ignored; single done with lt=1; no second done without a new start in IDLE.
- Reset mid-operation: start a=8'h33, b=8'h22; assert rst at cycle 4 -> busy, done, gt, lt, eq all 0 immediately, with no done pulse. Release rst, then start a=8'h01, b=8'h02 -> lt=1 after 8 cycles.
- Wide chunking: WIDTH=16, CHUNK=4, a=16'h1234, b=16'h1235, signed_mode=0 -> done 4 cycles after start, lt=1. Also a=b=16'hFFFF -> eq=1 after 4 cycles.
